// File: rtl/sram_bus_capture_if.sv
// ============================================================================
// Module  : sram_bus_capture_if
// Purpose : SRAM bus pins, transceiver controls and capture record stream
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface sram_bus_capture_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              sram_n_write;
  logic              sram_n_oe;
  logic              sram_n_ce;
  logic              trans_tx_data;
  logic              trans_tx_addr;
  logic              trans_n_oe;
  logic              cap_valid;
  logic              cap_ready;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic              cap_is_write;
  logic              overflow;
  logic              overflow_clr;
  logic [15:0]       write_count;
  logic [15:0]       read_count;

  // master = capture stage, slave = host bus model plus record consumer
  modport master (
    input  addr, data, sram_n_write, sram_n_oe, sram_n_ce, cap_ready, overflow_clr,
    output trans_tx_data, trans_tx_addr, trans_n_oe, cap_valid, cap_addr, cap_data,
           cap_is_write, overflow, write_count, read_count
  );

  modport slave (
    output addr, data, sram_n_write, sram_n_oe, sram_n_ce, cap_ready, overflow_clr,
    input  trans_tx_data, trans_tx_addr, trans_n_oe, cap_valid, cap_addr, cap_data,
           cap_is_write, overflow, write_count, read_count
  );
endinterface

`default_nettype wire

// File: rtl/sram_bus_capture.sv
// ============================================================================
// Module  : sram_bus_capture
// Purpose : Synchronise SRAM bus, detect write/read cycles, queue records
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sram_bus_capture #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  sram_bus_capture_if.master  bus
);

  localparam int         PTR_W      = $clog2(FIFO_DEPTH);
  localparam int         REC_W      = ADDR_W + DATA_W + 1;
  localparam logic [2:0] C_CTL_IDLE = 3'b111;
  localparam logic [PTR_W:0] C_PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  // control bit order: {n_ce, n_oe, n_write}
  logic [ADDR_W-1:0] addr_sync_q [SYNC_STAGES];
  logic [DATA_W-1:0] data_sync_q [SYNC_STAGES];
  logic [2:0]        ctl_sync_q  [SYNC_STAGES];
  logic [2:0]        ctl_p_q;
  logic              trans_n_oe_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_sync_q[i] <= '0;
        data_sync_q[i] <= '0;
        ctl_sync_q[i]  <= C_CTL_IDLE;
      end
      ctl_p_q      <= C_CTL_IDLE;
      trans_n_oe_q <= 1'b1;
    end else begin
      addr_sync_q[0] <= bus.addr;
      data_sync_q[0] <= bus.data;
      ctl_sync_q[0]  <= {bus.sram_n_ce, bus.sram_n_oe, bus.sram_n_write};
      for (int i = 1; i < SYNC_STAGES; i++) begin
        addr_sync_q[i] <= addr_sync_q[i-1];
        data_sync_q[i] <= data_sync_q[i-1];
        ctl_sync_q[i]  <= ctl_sync_q[i-1];
      end
      ctl_p_q      <= ctl_sync_q[SYNC_STAGES-1];
      trans_n_oe_q <= 1'b0;
    end
  end

  logic n_ce_s, n_oe_s, n_write_s;
  logic n_ce_p, n_oe_p, n_write_p;
  assign {n_ce_s, n_oe_s, n_write_s} = ctl_sync_q[SYNC_STAGES-1];
  assign {n_ce_p, n_oe_p, n_write_p} = ctl_p_q;

  // Snapshot tracks the bus while a strobe is low, so at the rising edge it
  // holds the last value sampled during the strobe.
  logic [ADDR_W-1:0] snap_addr_q;
  logic [DATA_W-1:0] snap_data_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snap_addr_q <= '0;
      snap_data_q <= '0;
    end else if (!n_ce_s && (!n_write_s || !n_oe_s)) begin
      snap_addr_q <= addr_sync_q[SYNC_STAGES-1];
      snap_data_q <= data_sync_q[SYNC_STAGES-1];
    end
  end

  logic wr_ev, rd_ev, ev_any;
  assign wr_ev  = !n_write_p && n_write_s && !n_ce_p;
  assign rd_ev  = !n_oe_p && n_oe_s && !n_ce_p;
  assign ev_any = wr_ev || rd_ev;

  logic [REC_W-1:0] rec_d;
  assign rec_d = {wr_ev, snap_addr_q, snap_data_q};

  logic [REC_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             empty, full, pop, push, drop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign pop   = !empty && bus.cap_ready;
  assign push  = ev_any && (!full || pop);
  // a simultaneous read is always lost because only one record fits per cycle
  assign drop  = (ev_any && !push) || (wr_ev && rd_ev);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q[PTR_W-1:0]] <= rec_d;
    end
  end

  logic        overflow_q, overflow_d;
  logic [15:0] write_count_q, write_count_d;
  logic [15:0] read_count_q, read_count_d;

  always_comb begin
    overflow_d    = overflow_q;
    if (bus.overflow_clr) overflow_d = 1'b0;
    if (drop)             overflow_d = 1'b1;
    write_count_d = write_count_q + {15'd0, wr_ev};
    read_count_d  = read_count_q + {15'd0, rd_ev};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      overflow_q    <= 1'b0;
      write_count_q <= '0;
      read_count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
      overflow_q    <= overflow_d;
      write_count_q <= write_count_d;
      read_count_q  <= read_count_d;
    end
  end

  logic [REC_W-1:0] head;
  assign head = empty ? '0 : fifo_q[rd_ptr_q[PTR_W-1:0]];

  assign bus.cap_valid     = !empty;
  assign bus.cap_is_write  = head[REC_W-1];
  assign bus.cap_addr      = head[DATA_W +: ADDR_W];
  assign bus.cap_data      = head[DATA_W-1:0];
  assign bus.overflow      = overflow_q;
  assign bus.write_count   = write_count_q;
  assign bus.read_count    = read_count_q;
  assign bus.trans_n_oe    = trans_n_oe_q;
  assign bus.trans_tx_data = 1'b0;
  assign bus.trans_tx_addr = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_sram_bus_capture.sv
// ============================================================================
// Module  : tb_sram_bus_capture
// Purpose : Directed scoreboard bench for sram_bus_capture
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sram_bus_capture;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              w;
  } rec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sram_bus_capture_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  sram_bus_capture #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(8), .SYNC_STAGES(2)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_if.master)
  );

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wc = 0;
  int   rc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor: every accepted head record must match the scoreboard front
  always @(negedge clk) begin : mon
    rec_t e;
    if (reset_n === 1'b1 && bus_if.cap_valid === 1'b1 && bus_if.cap_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_record: got addr=0x%0h data=0x%0h w=%0b expected none",
                 bus_if.cap_addr, bus_if.cap_data, bus_if.cap_is_write);
      end else begin
        e = exp_q.pop_front();
        if (bus_if.cap_addr !== e.a || bus_if.cap_data !== e.d || bus_if.cap_is_write !== e.w) begin
          errors++;
          $display("FAIL record: got addr=0x%0h data=0x%0h w=%0b expected addr=0x%0h data=0x%0h w=%0b",
                   bus_if.cap_addr, bus_if.cap_data, bus_if.cap_is_write, e.a, e.d, e.w);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input bit wr, input bit rd, input bit ce);
    bus_if.addr         = a;
    bus_if.data         = d;
    bus_if.sram_n_ce    = !ce;
    bus_if.sram_n_write = !wr;
    bus_if.sram_n_oe    = !rd;
    tick(4);
    bus_if.sram_n_write = 1'b1;
    bus_if.sram_n_oe    = 1'b1;
    tick(1);
    bus_if.sram_n_ce    = 1'b1;
    tick(2);
  endtask

  initial begin
    reset_n             = 1'b0;
    bus_if.addr         = '0;
    bus_if.data         = '0;
    bus_if.sram_n_write = 1'b1;
    bus_if.sram_n_oe    = 1'b1;
    bus_if.sram_n_ce    = 1'b1;
    bus_if.cap_ready    = 1'b1;
    bus_if.overflow_clr = 1'b0;

    // reset and idle bus
    tick(3);
    check("rst_trans_n_oe", 32'(bus_if.trans_n_oe), 32'd1);
    check("rst_cap_valid", 32'(bus_if.cap_valid), 32'd0);
    check("rst_cap_addr", 32'(bus_if.cap_addr), 32'd0);
    check("rst_write_count", 32'(bus_if.write_count), 32'd0);
    check("rst_read_count", 32'(bus_if.read_count), 32'd0);
    check("rst_overflow", 32'(bus_if.overflow), 32'd0);
    reset_n = 1'b1;
    #1;
    check("trans_n_oe_at_release", 32'(bus_if.trans_n_oe), 32'd1);
    tick(1);
    check("trans_n_oe_after_edge", 32'(bus_if.trans_n_oe), 32'd0);
    check("trans_tx_dirs", 32'({bus_if.trans_tx_data, bus_if.trans_tx_addr}), 32'd0);
    tick(3);

    // single write with latency probe
    exp_q.push_back('{a: 15'h1234, d: 8'hA5, w: 1'b1});
    wc++;
    bus_if.addr         = 15'h1234;
    bus_if.data         = 8'hA5;
    bus_if.sram_n_ce    = 1'b0;
    bus_if.sram_n_write = 1'b0;
    tick(4);
    bus_if.sram_n_write = 1'b1;
    tick(1);
    check("lat_valid_e1", 32'(bus_if.cap_valid), 32'd0);
    tick(1);
    check("lat_valid_e2", 32'(bus_if.cap_valid), 32'd0);
    tick(1);
    check("lat_valid_e3", 32'(bus_if.cap_valid), 32'd1);
    check("wr_cap_addr", 32'(bus_if.cap_addr), 32'h1234);
    check("wr_cap_data", 32'(bus_if.cap_data), 32'hA5);
    check("wr_cap_is_write", 32'(bus_if.cap_is_write), 32'd1);
    tick(1);
    check("lat_valid_e4", 32'(bus_if.cap_valid), 32'd0);
    bus_if.sram_n_ce = 1'b1;
    tick(2);
    check("write_count_1", 32'(bus_if.write_count), 32'(wc));

    // read selected, then the same read deselected
    exp_q.push_back('{a: 15'h7FFF, d: 8'h3C, w: 1'b0});
    rc++;
    strobe(15'h7FFF, 8'h3C, 1'b0, 1'b1, 1'b1);
    strobe(15'h7FFF, 8'h3C, 1'b0, 1'b1, 1'b0);
    tick(2);
    check("read_count_1", 32'(bus_if.read_count), 32'(rc));
    check("rd_no_extra_valid", 32'(bus_if.cap_valid), 32'd0);

    // fill past depth with consumer stalled
    bus_if.cap_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) exp_q.push_back('{a: 15'(16'h0100 + i), d: 8'(i), w: 1'b1});
      wc++;
      strobe(15'(16'h0100 + i), 8'(i), 1'b1, 1'b0, 1'b1);
    end
    check("fill_overflow", 32'(bus_if.overflow), 32'd1);
    check("fill_write_count", 32'(bus_if.write_count), 32'(wc));
    check("fill_head_data", 32'(bus_if.cap_data), 32'd0);
    bus_if.cap_ready = 1'b1;
    tick(12);
    check("drain_valid", 32'(bus_if.cap_valid), 32'd0);
    check("drain_sb_empty", 32'(exp_q.size()), 32'd0);
    bus_if.overflow_clr = 1'b1;
    tick(1);
    bus_if.overflow_clr = 1'b0;
    check("overflow_cleared", 32'(bus_if.overflow), 32'd0);

    // write and read released together
    exp_q.push_back('{a: 15'h0055, d: 8'h77, w: 1'b1});
    wc++;
    rc++;
    strobe(15'h0055, 8'h77, 1'b1, 1'b1, 1'b1);
    tick(2);
    check("both_overflow", 32'(bus_if.overflow), 32'd1);
    check("both_write_count", 32'(bus_if.write_count), 32'(wc));
    check("both_read_count", 32'(bus_if.read_count), 32'(rc));
    bus_if.overflow_clr = 1'b1;
    tick(1);
    bus_if.overflow_clr = 1'b0;

    // reset with records queued and a strobe held low across release
    bus_if.cap_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{a: 15'(16'h0200 + i), d: 8'(8'h40 + i), w: 1'b1});
      strobe(15'(16'h0200 + i), 8'(8'h40 + i), 1'b1, 1'b0, 1'b1);
    end
    check("queued_valid", 32'(bus_if.cap_valid), 32'd1);
    bus_if.sram_n_ce    = 1'b0;
    bus_if.sram_n_write = 1'b0;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus_if.cap_valid), 32'd0);
    check("async_rst_wcount", 32'(bus_if.write_count), 32'd0);
    check("async_rst_rcount", 32'(bus_if.read_count), 32'd0);
    exp_q.delete();
    wc = 0;
    rc = 0;
    tick(2);
    reset_n = 1'b1;
    bus_if.cap_ready = 1'b1;
    tick(6);
    check("held_low_no_valid", 32'(bus_if.cap_valid), 32'd0);
    bus_if.sram_n_ce = 1'b1;
    tick(4);
    bus_if.sram_n_write = 1'b1;
    tick(5);
    check("deselected_rise_wcount", 32'(bus_if.write_count), 32'd0);
    check("deselected_rise_valid", 32'(bus_if.cap_valid), 32'd0);
    exp_q.push_back('{a: 15'h2AAA, d: 8'h5A, w: 1'b1});
    wc++;
    strobe(15'h2AAA, 8'h5A, 1'b1, 1'b0, 1'b1);
    tick(3);
    check("post_rst_wcount", 32'(bus_if.write_count), 32'(wc));
    check("final_sb_empty", 32'(exp_q.size()), 32'd0);
    check("final_overflow", 32'(bus_if.overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
